// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared definitions for the nibble-serial subtractor: FSM encoding, group size, width legality.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nibble_serial_subtractor_pkg;

    // Controller states; the encoding is fixed so debug views match the datapath documentation.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits processed per RUN cycle.
    localparam int GROUP = 4;

    // Operand width must split into whole groups and give at least two of them.
    function automatic bit width_ok(input int w);
        return ((w % GROUP) == 0) && (w >= 2 * GROUP);
    endfunction

endpackage

// File: rtl/nibble_serial_subtractor_borrow_lookahead_4.sv
// 4-bit borrow-lookahead subtract slice: d = a - b - bin with group generate/propagate.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle by the owning controller.
module borrow_lookahead_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout,
    output logic       BG,
    output logic       BP
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_bi;

    // Per-bit borrow generate (0 - 1) and propagate (equal bits pass the incoming borrow).
    assign w_g = ~a & b;
    assign w_p = ~(a ^ b);

    // Borrow into each bit, flattened so every term depends only on g/p and bin.
    assign w_bi[0] = bin;
    assign w_bi[1] = w_g[0] | (w_p[0] & bin);
    assign w_bi[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & bin);
    assign w_bi[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                   | (w_p[2] & w_p[1] & w_p[0] & bin);

    assign d = a ^ b ^ w_bi;

    // Group terms, usable by a higher lookahead level as well as for the local borrow-out.
    assign BG = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign BP = &w_p;
    assign bout = BG | (BP & bin);

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle D = A - B - Bi, one 4-bit group per clock with a registered borrow between groups.
// Latency: WIDTH/4 + 1 cycles from the accepting edge to the done pulse.
// Backpressure: start is ignored while busy; accepted again in IDLE or on the done cycle.
module nibble_serial_subtractor
    import nibble_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bo,
    output logic             V,
    output logic             Z
);

    localparam int N  = WIDTH / GROUP;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("nibble_serial_subtractor: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_next;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_bor;
    logic [WIDTH-1:0] r_d;
    logic             r_bo;
    logic             r_v;
    logic             r_z;

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic [3:0]       w_nib_d;
    logic             w_nib_bout;
    logic             w_nib_bg;
    logic             w_nib_bp;
    logic [WIDTH-1:0] w_d_next;

    assign w_run    = (r_state == ST_RUN);
    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = w_run && (r_k == KW'(N - 1));

    // Operands shift right each RUN cycle, so the active group always sits in the low nibble.
    borrow_lookahead_4 u_bla (
        .a    (r_a[GROUP-1:0]),
        .b    (r_b[GROUP-1:0]),
        .bin  (r_bor),
        .d    (w_nib_d),
        .bout (w_nib_bout),
        .BG   (w_nib_bg),
        .BP   (w_nib_bp)
    );

    // Group terms are only consumed inside the slice here; bout already folds them in.
    logic w_unused_grp;
    assign w_unused_grp = w_nib_bg ^ w_nib_bp;

    // Next-state decode for the IDLE -> RUN (N cycles) -> DONE controller.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = start ? ST_RUN : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Difference register with the current group's nibble written in at index k.
    always_comb begin
        w_d_next = r_d;
        for (int g = 0; g < N; g++) begin
            if (r_k == KW'(g)) w_d_next[g*GROUP +: GROUP] = w_nib_d;
        end
    end

    // Operand capture, per-group stepping, and flag update on the final group.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_bor   <= 1'b0;
            r_d     <= '0;
            r_bo    <= 1'b0;
            r_v     <= 1'b0;
            r_z     <= 1'b0;
        end else if (w_accept) begin
            r_k     <= '0;
            r_a     <= A;
            r_b     <= B;
            r_a_msb <= A[WIDTH-1];
            r_b_msb <= B[WIDTH-1];
            r_bor   <= Bi;
        end else if (w_run) begin
            r_a   <= r_a >> GROUP;
            r_b   <= r_b >> GROUP;
            r_bor <= w_nib_bout;
            r_d   <= w_d_next;
            r_k   <= w_last ? '0 : r_k + KW'(1);
            if (w_last) begin
                r_bo <= w_nib_bout;
                r_v  <= (r_a_msb != r_b_msb) && (w_d_next[WIDTH-1] != r_a_msb);
                r_z  <= (w_d_next == '0);
            end
        end
    end

    assign busy = w_run;
    assign done = (r_state == ST_DONE);
    assign D    = r_d;
    assign Bo   = r_bo;
    assign V    = r_v;
    assign Z    = r_z;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor (WIDTH = 16) against an arithmetic model.
// Latency: expects done 5 cycles after the accepting edge.
// Backpressure: exercises start held during RUN and start on the done cycle.
module tb_nibble_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        Bi;
    logic        busy;
    logic        done;
    logic [15:0] D;
    logic        Bo;
    logic        V;
    logic        Z;

    int n_cmp = 0;
    int n_err = 0;

    nibble_serial_subtractor #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bi    (Bi),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bo    (Bo),
        .V     (V),
        .Z     (Z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer subtraction, unsigned borrow and signed range check.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic bi,
                         output logic [15:0] d, output logic bo, output logic v, output logic z);
        int ua;
        int ub;
        int sa;
        int sb;
        int sr;
        int ur;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ur = ua - ub - int'(bi);
        sr = sa - sb - int'(bi);
        d  = 16'(ur & 32'hFFFF);
        bo = (ur < 0);
        v  = (sr > 32767) || (sr < -32768);
        z  = (d == 16'h0000);
    endtask

    // Present operands with start at a falling edge; returns at the falling edge of RUN cycle 1.
    task automatic op_start(input logic [15:0] a, input logic [15:0] b, input logic bi);
        A = a;
        B = b;
        Bi = bi;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // From RUN cycle 1, wait (bounded) for done and check latency and results.
    task automatic wait_done(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic bi);
        int lat;
        logic [15:0] ed;
        logic eb;
        logic ev;
        logic ez;
        lat = 1;
        chk({tag, ".busy1"}, 32'(busy), 32'd1);
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        model(a, b, bi, ed, eb, ev, ez);
        chk({tag, ".lat"}, 32'(lat), 32'd5);
        chk({tag, ".D"}, 32'(D), 32'(ed));
        chk({tag, ".Bo"}, 32'(Bo), 32'(eb));
        chk({tag, ".V"}, 32'(V), 32'(ev));
        chk({tag, ".Z"}, 32'(Z), 32'(ez));
        chk({tag, ".busy0"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rbi;
        int          seen;

        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        Bi = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.D", 32'(D), 32'd0);
        chk("rst.flags", {29'd0, Bo, V, Z}, 32'd0);

        // Directed cases.
        op_start(16'h1234, 16'h0234, 1'b0);
        wait_done("basic", 16'h1234, 16'h0234, 1'b0);
        chk("basic.Dconst", 32'(D), 32'h1000);
        @(negedge clk);
        chk("basic.idle_done", 32'(done), 32'd0);

        op_start(16'h0000, 16'h0001, 1'b0);
        wait_done("under", 16'h0000, 16'h0001, 1'b0);
        chk("under.Bconst", {15'd0, Bo, D}, {15'd0, 1'b1, 16'hFFFF});
        @(negedge clk);

        op_start(16'h8000, 16'h0001, 1'b0);
        wait_done("ovf", 16'h8000, 16'h0001, 1'b0);
        chk("ovf.Vconst", {15'd0, V, D}, {15'd0, 1'b1, 16'h7FFF});
        @(negedge clk);

        op_start(16'h5555, 16'h5554, 1'b1);
        wait_done("zero", 16'h5555, 16'h5554, 1'b1);
        chk("zero.Zconst", 32'(Z), 32'd1);
        @(negedge clk);
        chk("zero.hold", {15'd0, Z, D}, {15'd0, 1'b1, 16'h0000});

        // start held through RUN with different operands, then back-to-back from DONE.
        op_start(16'h1234, 16'h0234, 1'b0);
        start = 1'b1;
        A = 16'hFFFF;
        B = 16'h0F0F;
        Bi = 1'b1;
        wait_done("held", 16'h1234, 16'h0234, 1'b0);
        op_start(16'h0010, 16'h0001, 1'b0);
        wait_done("b2b", 16'h0010, 16'h0001, 1'b0);
        chk("b2b.Dconst", 32'(D), 32'h000F);
        @(negedge clk);

        // Reset during RUN aborts the operation without a done pulse.
        op_start(16'h1234, 16'h0001, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.D", 32'(D), 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) seen++;
            @(negedge clk);
        end
        chk("abort.nodone", 32'(seen), 32'd0);
        op_start(16'hABCD, 16'h1234, 1'b1);
        wait_done("after_abort", 16'hABCD, 16'h1234, 1'b1);
        @(negedge clk);

        // Randomized operands, borrow-in and spacing, including equal operands.
        for (int i = 0; i < 24; i++) begin
            ra  = 16'($urandom);
            rb  = (i % 6 == 0) ? ra : 16'($urandom);
            rbi = 1'($urandom_range(0, 1));
            op_start(ra, rb, rbi);
            wait_done($sformatf("rnd%0d", i), ra, rb, rbi);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nibble_serial_subtractor.md
# nibble_serial_subtractor

Multi-cycle WIDTH-bit subtractor computing D = A − B − Bi one 4-bit group per clock, using borrow generate/propagate lookahead inside each group and a registered borrow between groups. It is the subtraction counterpart of the datapath's carry-lookahead adder. It serves the lecture ALU's compare/subtract path, where area matters more than latency. Operands are captured on a start pulse, and results are returned with a one-cycle done pulse.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 8.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- A  in  WIDTH  minuend; captured when start is accepted.
- B  in  WIDTH  subtrahend; captured when start is accepted.
- Bi  in  1  borrow-in; captured when start is accepted.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the result becomes valid.
- D  out  WIDTH  difference; registered.
- Bo  out  1  final borrow-out (1 = unsigned A < B + Bi).
- V  out  1  two's-complement overflow.
- Z  out  1  high when D == 0.

## Operation
- FSM states and transitions:
  - IDLE: start → RUN; otherwise stay in IDLE.
  - RUN: stay for N = WIDTH/4 cycles, then → DONE.
  - DONE: held for one cycle only. start → RUN (back-to-back operation); otherwise → IDLE.
- On accept, register A, B and Bi; clear the group index k to 0; the borrow register takes Bi.
- Per-bit borrow terms for each RUN cycle:
  - generate g = ~a & b
  - propagate p = ~(a ^ b)
  - borrow chain b(i+1) = g(i) | p(i)&b(i)
  - difference d(i) = a(i) ^ b(i) ^ b_in(i)
- Per-group terms:
  - BG = g3 | p3g2 | p3p2g1 | p3p2p1g0
  - BP = p3p2p1p0
  - group borrow-out = BG | BP&bin
- Each RUN cycle writes D[4k+3:4k], updates the borrow register with the group borrow-out, and increments k.
- Result flags:
  - Bo = borrow register after the last group.
  - V = (A[MSB] != B[MSB]) & (D[MSB] != A[MSB]), using the captured operands.
  - Z = (D == 0).
- start while busy is ignored: no re-capture and no effect on the operation in progress.
- Changes on A/B/Bi after capture have no effect.
- D, Bo, V and Z hold their values from DONE until the next accepted start. The upper D nibbles may show stale data during RUN; only the values at done are defined.
- Reset state: FSM in IDLE, k = 0, busy = 0, done = 0, D = 0, Bo = 0, V = 0, Z = 0.
- rst mid-operation aborts the operation: all outputs take their reset values at the next edge, and no done pulse is produced.

## Timing
- Cycle 0: start accepted (IDLE or DONE).
- Cycles 1..N: RUN, busy = 1, one nibble per cycle.
- Cycle N+1: DONE, done = 1, busy = 0; D, Bo, V and Z are valid.
- Latency from the accepting edge to done is N+1 cycles (5 for WIDTH = 16).
- Throughput is one result per N+1 cycles when start is asserted during DONE.
- The lookahead path is combinational within one cycle; there is no combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - FSM state encoding: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - GROUP = 4.
  - The WIDTH legality check.
- Sub-module borrow_lookahead_4 (purely combinational):
  - Inputs: a[3:0], b[3:0], bin.
  - Outputs: d[3:0], bout, BG, BP.
  - It is the subtract-side mirror of the 4-bit carry-lookahead unit, and is instantiated once.
- Top level holds the FSM, the group counter, the operand shift-or-index logic, the borrow register and the flag logic.

## Test plan
- WIDTH = 16 basic subtract: A = 0x1234, B = 0x0234, Bi = 0, start at cycle 0 → busy during cycles 1–4; done at cycle 5 with D = 0x1000, Bo = 0, V = 0, Z = 0.
- Underflow: A = 0x0000, B = 0x0001 → D = 0xFFFF, Bo = 1, V = 0, Z = 0.
- Signed overflow: A = 0x8000, B = 0x0001 → D = 0x7FFF, Bo = 0, V = 1.
- Borrow-in and zero: A = 0x5555, B = 0x5554, Bi = 1 → D = 0x0000, Z = 1, Bo = 0.
- start held high in RUN with new operands → ignored; the first result is unchanged. Then start on the done cycle with A = 0x0010, B = 0x0001 → second done exactly 5 cycles later with D = 0x000F.
- rst asserted at cycle 2 of RUN → next edge gives busy = 0, D = 0; no done pulse; a following start completes normally.
